// File: rtl/instr_fetch_unit.sv
// Fetch stage: fetch PC, in-order req/gnt + rvalid memory port, response FIFO.
// Optional IFU_MISALIGN_CHECK_EN adds misalign_o and blocks fetch on unaligned redirects.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_sel_i,
    input  logic [31:0] alu_i,
    input  logic        stall_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
`ifdef IFU_MISALIGN_CHECK_EN
    output logic        misalign_o,
`endif
    output logic        inst_valid_o
);
    localparam int unsigned OW = $clog2(FIFO_DEPTH + 2);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fifo_ent_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [31:0]   pend_addr_q, pend_addr_d;
    logic          pend_q, pend_d;
    logic [OW-1:0] out_q, out_d;
    logic [OW-1:0] drop_q, drop_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    fifo_ent_t     fifo_q [FIFO_DEPTH];
    logic [31:0]   last_pc_q;
    logic          mis_q;
    logic [31:0]   target;
    logic [31:0]   inflight;
    logic          resp_ok, req_fire, push, pop, issue_ok;

`ifdef IFU_MISALIGN_CHECK_EN
    logic mis_d;
    assign target = alu_i;
`else
    assign target = alu_i & ~32'h3;
`endif

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign inst_valid_o = (cnt_q != '0);
    assign inst_o       = inst_valid_o ? fifo_q[rd_q].inst : NOP_INST;
    assign pc_o         = inst_valid_o ? fifo_q[rd_q].pc : last_pc_q;

    // A word leaving this cycle frees its slot, so the stream runs back-to-back.
    assign pop      = inst_valid_o && !stall_i && !pc_sel_i;
    assign inflight = 32'(out_q) + 32'(cnt_q) - 32'(pop);
    assign issue_ok = (state_q == FETCH) && !mis_q
                      && (inflight < 32'(FIFO_DEPTH));

    assign imem_req_o  = pend_q || issue_ok;
    assign imem_addr_o = pend_q ? pend_addr_q : fetch_pc_q;
    assign req_fire    = imem_req_o && imem_gnt_i;
    assign resp_ok     = imem_rvalid_i && (out_q != '0);
    assign push        = resp_ok && (drop_q == '0) && !pc_sel_i;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        resp_pc_d   = resp_pc_q;
        pend_d      = imem_req_o && !imem_gnt_i;
        pend_addr_d = imem_addr_o;
        out_d       = out_q + OW'(req_fire) - OW'(resp_ok);
        drop_d      = drop_q - OW'(resp_ok && (drop_q != '0));
        cnt_d       = cnt_q + CW'(push) - CW'(pop);
        rd_d        = pop ? nxt(rd_q) : rd_q;
        wr_d        = push ? nxt(wr_q) : wr_q;
`ifdef IFU_MISALIGN_CHECK_EN
        mis_d       = mis_q;
`endif

        unique case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   state_d = FETCH;
            FLUSH: begin
                if (drop_q == '0 && !pend_q) state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase

        if (push) resp_pc_d = resp_pc_q + 32'd4;
        if (req_fire && state_q == FETCH) fetch_pc_d = fetch_pc_q + 32'd4;

        if (pc_sel_i) begin
            state_d    = FLUSH;
            fetch_pc_d = target;
            resp_pc_d  = target;
            cnt_d      = '0;
            rd_d       = '0;
            wr_d       = '0;
            // Every response still owed, including a stale ungranted request.
            if (state_q != FLUSH)
                drop_d = out_d + OW'(imem_req_o && !imem_gnt_i);
`ifdef IFU_MISALIGN_CHECK_EN
            mis_d = (alu_i[1:0] != 2'b00);
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            resp_pc_q   <= RESET_PC;
            pend_addr_q <= RESET_PC;
            pend_q      <= 1'b0;
            out_q       <= '0;
            drop_q      <= '0;
            cnt_q       <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            last_pc_q   <= RESET_PC;
            for (int i = 0; i < int'(FIFO_DEPTH); i++)
                fifo_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            resp_pc_q   <= resp_pc_d;
            pend_addr_q <= pend_addr_d;
            pend_q      <= pend_d;
            out_q       <= out_d;
            drop_q      <= drop_d;
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            last_pc_q   <= pc_o;
            if (push)
                fifo_q[wr_q] <= {imem_rdata_i, resp_pc_q};
        end
    end

`ifdef IFU_MISALIGN_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mis_q <= 1'b0;
        else     mis_q <= mis_d;
    end

    assign misalign_o = mis_q;
`else
    assign mis_q = 1'b0;
`endif

endmodule
